// File: rtl/serial_word_feeder.sv
// Serializes a parallel word LSB-first into shift_en/shift_in, then holds extend for signed words; FEEDER_ABORT_EN adds an abort input.
// Latency: bit i on shift_in in cycle N+1+i after accept edge N; done pulse x+1 (+EXT_CYCLES if signed) cycles after accept.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, so upstream holds it until accepted.
module serial_word_feeder #(
    parameter int x          = 8,
    parameter int EXT_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
`ifdef FEEDER_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [x-1:0] in_data,
    input  logic         in_signed,
    output logic         shift_en,
    output logic         shift_in,
    output logic         extend,
    output logic         busy,
    output logic         done
);

    localparam int CW = (x > 1) ? $clog2(x) : 1;
    localparam int EW = (EXT_CYCLES > 0) ? $clog2(EXT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(x - 1);
    localparam logic [EW-1:0] EXT_LOAD = EW'((EXT_CYCLES > 0) ? EXT_CYCLES - 1 : 0);
    localparam bit            EXT_ON   = (EXT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, SHIFT, EXTEND, DONE} state_t;

    state_t        state, state_nxt;
    logic [x-1:0]  data_buf;
    logic          sgn;
    logic [CW-1:0] bit_cnt;
    logic [EW-1:0] ext_cnt;
    logic          abort_hit;

`ifdef FEEDER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_buf <= '0;
            sgn      <= 1'b0;
            bit_cnt  <= '0;
            ext_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_buf <= in_data;
                        sgn      <= in_signed;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    data_buf <= {1'b0, data_buf[x-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        ext_cnt <= EXT_LOAD;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                EXTEND: begin
                    if (ext_cnt != '0) ext_cnt <= ext_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (abort_hit)                state_nxt = IDLE;
                else if (bit_cnt == LAST_BIT) state_nxt = (sgn && EXT_ON) ? EXTEND : DONE;
            end
            EXTEND: begin
                // ext_cnt counts the remaining extend cycles after this one
                if (abort_hit)            state_nxt = IDLE;
                else if (ext_cnt == '0)   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        shift_en = 1'b0;
        shift_in = 1'b0;
        extend   = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:   in_ready = 1'b1;
            SHIFT: begin
                shift_en = 1'b1;
                shift_in = data_buf[0];
            end
            EXTEND: extend = 1'b1;
            DONE:   done   = 1'b1;
            default: ;
        endcase
    end

endmodule
